// File: rtl/decode_pipe.sv
// Decode stage for the WISC-SP13 pipeline: register file with write-through, immediate
// extension, load-use hazard detection and a backpressured, flushable ID/EX register.
module decode_pipe #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int CTRL_W   = 16,
    localparam int REG_AW  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              ctrl_err,
    input  logic              uses_a,
    input  logic              uses_b,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_is_load,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_sel,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_ready,
    input  logic              ex_flush,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_dst,
    output logic              ex_is_load,
    output logic [DATA_W-1:0] ex_se4,
    output logic [DATA_W-1:0] ex_ze4,
    output logic [DATA_W-1:0] ex_se7,
    output logic [DATA_W-1:0] ex_ze7,
    output logic [DATA_W-1:0] ex_se10,
    output logic              err
);

    function automatic logic signed [DATA_W-1:0] sext5(input logic [4:0] f);
        return {{(DATA_W-5){f[4]}}, f};
    endfunction

    function automatic logic signed [DATA_W-1:0] sext8(input logic [7:0] f);
        return {{(DATA_W-8){f[7]}}, f};
    endfunction

    function automatic logic signed [DATA_W-1:0] sext11(input logic [10:0] f);
        return {{(DATA_W-11){f[10]}}, f};
    endfunction

    function automatic logic [DATA_W-1:0] zext5(input logic [4:0] f);
        return {{(DATA_W-5){1'b0}}, f};
    endfunction

    function automatic logic [DATA_W-1:0] zext8(input logic [7:0] f);
        return {{(DATA_W-8){1'b0}}, f};
    endfunction

    logic signed [DATA_W-1:0] rf [NUM_REGS];

    logic [REG_AW-1:0]        rs_p0, rt_p0;
    logic signed [DATA_W-1:0] a_p0, b_p0;
    logic                     hazard, advance;
    logic                     unused_instr;

    logic                     vld_p1;
    logic [CTRL_W-1:0]        ctrl_p1;
    logic signed [DATA_W-1:0] a_p1, b_p1, se4_p1, se7_p1, se10_p1;
    logic [DATA_W-1:0]        ze4_p1, ze7_p1;
    logic [REG_AW-1:0]        rs_p1, rt_p1, dst_p1;
    logic                     is_load_p1;
    logic                     err_p1;

    // Decode stage (p0): register reads with write-through and hazard detection
    assign rs_p0        = instr[8 +: REG_AW];
    assign rt_p0        = instr[5 +: REG_AW];
    assign unused_instr = ^instr;

    assign a_p0 = (wb_we && wb_sel == rs_p0) ? wb_data : rf[rs_p0];
    assign b_p0 = (wb_we && wb_sel == rt_p0) ? wb_data : rf[rt_p0];

    assign hazard   = instr_valid & vld_p1 & is_load_p1 &
                      ((uses_a & (rs_p0 == dst_p1)) | (uses_b & (rt_p0 == dst_p1)));
    assign advance  = !vld_p1 | ex_ready;
    assign id_stall = !ex_flush & instr_valid & (!advance | hazard);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else if (wb_we) begin
            rf[wb_sel] <= wb_data;
        end
    end

    // ID/EX stage (p1): flush beats hold, hold beats bubble, bubble beats capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            ctrl_p1    <= '0;
            a_p1       <= '0;
            b_p1       <= '0;
            se4_p1     <= '0;
            ze4_p1     <= '0;
            se7_p1     <= '0;
            ze7_p1     <= '0;
            se10_p1    <= '0;
            rs_p1      <= '0;
            rt_p1      <= '0;
            dst_p1     <= '0;
            is_load_p1 <= 1'b0;
            err_p1     <= 1'b0;
        end else if (ex_flush) begin
            vld_p1 <= 1'b0;
        end else if (advance) begin
            if (hazard) begin
                vld_p1 <= 1'b0;
            end else begin
                vld_p1     <= instr_valid;
                ctrl_p1    <= ctrl_in;
                a_p1       <= a_p0;
                b_p1       <= b_p0;
                se4_p1     <= sext5(instr[4:0]);
                ze4_p1     <= zext5(instr[4:0]);
                se7_p1     <= sext8(instr[7:0]);
                ze7_p1     <= zext8(instr[7:0]);
                se10_p1    <= sext11(instr[10:0]);
                rs_p1      <= rs_p0;
                rt_p1      <= rt_p0;
                dst_p1     <= id_dst;
                is_load_p1 <= id_is_load;
                if (instr_valid && ctrl_err) err_p1 <= 1'b1;
            end
        end
    end

    assign ex_valid   = vld_p1;
    assign ex_ctrl    = ctrl_p1;
    assign ex_a       = a_p1;
    assign ex_b       = b_p1;
    assign ex_se4     = se4_p1;
    assign ex_ze4     = ze4_p1;
    assign ex_se7     = se7_p1;
    assign ex_ze7     = ze7_p1;
    assign ex_se10    = se10_p1;
    assign ex_rs      = rs_p1;
    assign ex_rt      = rt_p1;
    assign ex_dst     = dst_p1;
    assign ex_is_load = is_load_p1;
    assign err        = err_p1;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe at DATA_W=32: a vector table for operands/immediates,
// then hand-written sequences for load-use, backpressure, flush, err and mid-stream reset.
module tb_decode_pipe;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              instr_valid;
    logic [15:0]       instr;
    logic [CTRL_W-1:0] ctrl_in;
    logic              ctrl_err, uses_a, uses_b;
    logic [2:0]        id_dst;
    logic              id_is_load, wb_we;
    logic [2:0]        wb_sel;
    logic [DATA_W-1:0] wb_data;
    logic              ex_ready, ex_flush;
    logic              id_stall, ex_valid, ex_is_load, err;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [DATA_W-1:0] ex_a, ex_b, ex_se4, ex_ze4, ex_se7, ex_ze7, ex_se10;
    logic [2:0]        ex_rs, ex_rt, ex_dst;

    int n_cmp = 0;
    int n_fail = 0;

    decode_pipe #(.DATA_W(DATA_W), .NUM_REGS(8), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .ctrl_in(ctrl_in), .ctrl_err(ctrl_err), .uses_a(uses_a), .uses_b(uses_b),
        .id_dst(id_dst), .id_is_load(id_is_load), .wb_we(wb_we), .wb_sel(wb_sel),
        .wb_data(wb_data), .ex_ready(ex_ready), .ex_flush(ex_flush),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
        .ex_a(ex_a), .ex_b(ex_b), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
        .ex_is_load(ex_is_load), .ex_se4(ex_se4), .ex_ze4(ex_ze4), .ex_se7(ex_se7),
        .ex_ze7(ex_ze7), .ex_se10(ex_se10), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] ctrl;
        logic        we;
        logic [2:0]  sel;
        logic [31:0] wdata;
        logic [31:0] a, b, se4, ze4, se7, ze7, se10;
        logic [2:0]  rs, rt;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] ins, input logic ua, input logic ub,
                         input logic [2:0] dst, input logic ld);
        instr_valid = 1'b1;
        instr       = ins;
        uses_a      = ua;
        uses_b      = ub;
        id_dst      = dst;
        id_is_load  = ld;
    endtask

    initial begin
        vecs[0] = '{16'h0000, 16'h0001, 1'b1, 3'd3, 32'h1234, 32'h0, 32'h0,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 3'd0};
        vecs[1] = '{16'h0300, 16'h0002, 1'b0, 3'd0, 32'h0, 32'h1234, 32'h0,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'h300, 3'd3, 3'd0};
        vecs[2] = '{16'h03A0, 16'h0003, 1'b1, 3'd5, 32'hBEEF, 32'h1234, 32'hBEEF,
                    32'h0, 32'h0, 32'hFFFFFFA0, 32'hA0, 32'h3A0, 3'd3, 3'd5};
        vecs[3] = '{16'h0080, 16'h0004, 1'b1, 3'd0, 32'h55, 32'h55, 32'h0,
                    32'h0, 32'h0, 32'hFFFFFF80, 32'h80, 32'h80, 3'd0, 3'd4};
        vecs[4] = '{16'h041F, 16'h0005, 1'b0, 3'd0, 32'h0, 32'h0, 32'h55,
                    32'hFFFFFFFF, 32'h1F, 32'h1F, 32'h1F, 32'hFFFFFC1F, 3'd4, 3'd0};
        vecs[5] = '{16'hFFFF, 16'hA5A5, 1'b1, 3'd7, 32'hCAFE0001, 32'hCAFE0001, 32'hCAFE0001,
                    32'hFFFFFFFF, 32'h1F, 32'hFFFFFFFF, 32'hFF, 32'hFFFFFFFF, 3'd7, 3'd7};
        vecs[6] = '{16'h0210, 16'h5A5A, 1'b0, 3'd0, 32'h0, 32'h0, 32'h55,
                    32'hFFFFFFF0, 32'h10, 32'h10, 32'h10, 32'h210, 3'd2, 3'd0};

        rst = 1'b1; instr_valid = 1'b0; instr = '0; ctrl_in = '0; ctrl_err = 1'b0;
        uses_a = 1'b0; uses_b = 1'b0; id_dst = '0; id_is_load = 1'b0;
        wb_we = 1'b0; wb_sel = '0; wb_data = '0; ex_ready = 1'b1; ex_flush = 1'b0;
        step();
        step();
        chk("reset_ex_valid", 32'(ex_valid), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_ex_a", ex_a, 32'd0);
        chk("reset_ex_ctrl", 32'(ex_ctrl), 32'd0);
        chk("reset_id_stall", 32'(id_stall), 32'd0);
        rst = 1'b0;
        step();

        // Table: straight-line decode with EX always ready
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].instr, 1'b1, 1'b1, 3'(i), 1'b0);
            ctrl_in = vecs[i].ctrl;
            wb_we   = vecs[i].we;
            wb_sel  = vecs[i].sel;
            wb_data = vecs[i].wdata;
            #1;
            chk($sformatf("v%0d_id_stall", i), 32'(id_stall), 32'd0);
            step();
            chk($sformatf("v%0d_ex_valid", i), 32'(ex_valid), 32'd1);
            chk($sformatf("v%0d_ex_ctrl", i), 32'(ex_ctrl), 32'(vecs[i].ctrl));
            chk($sformatf("v%0d_ex_a", i), ex_a, vecs[i].a);
            chk($sformatf("v%0d_ex_b", i), ex_b, vecs[i].b);
            chk($sformatf("v%0d_se4", i), ex_se4, vecs[i].se4);
            chk($sformatf("v%0d_ze4", i), ex_ze4, vecs[i].ze4);
            chk($sformatf("v%0d_se7", i), ex_se7, vecs[i].se7);
            chk($sformatf("v%0d_ze7", i), ex_ze7, vecs[i].ze7);
            chk($sformatf("v%0d_se10", i), ex_se10, vecs[i].se10);
            chk($sformatf("v%0d_ex_rs", i), 32'(ex_rs), 32'(vecs[i].rs));
            chk($sformatf("v%0d_ex_rt", i), 32'(ex_rt), 32'(vecs[i].rt));
            chk($sformatf("v%0d_ex_dst", i), 32'(ex_dst), i);
        end
        wb_we = 1'b0;

        // Load-use on rs: one bubble, then issue
        drive(16'h0000, 1'b0, 1'b0, 3'd2, 1'b1);
        step();
        chk("ld_ex_is_load", 32'(ex_is_load), 32'd1);
        chk("ld_ex_dst", 32'(ex_dst), 32'd2);
        drive(16'h0200, 1'b1, 1'b0, 3'd1, 1'b0);
        #1;
        chk("lu_id_stall", 32'(id_stall), 32'd1);
        step();
        chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu_stall_cleared", 32'(id_stall), 32'd0);
        step();
        chk("lu_issue_valid", 32'(ex_valid), 32'd1);
        chk("lu_issue_rs", 32'(ex_rs), 32'd2);

        // Load-use on rt
        drive(16'h0000, 1'b0, 1'b0, 3'd5, 1'b1);
        step();
        drive(16'h00A0, 1'b0, 1'b1, 3'd1, 1'b0);
        #1;
        chk("lu_rt_id_stall", 32'(id_stall), 32'd1);
        step();
        chk("lu_rt_bubble", 32'(ex_valid), 32'd0);
        step();
        chk("lu_rt_issue_rt", 32'(ex_rt), 32'd5);

        // Same register but not read: no stall
        drive(16'h0000, 1'b0, 1'b0, 3'd2, 1'b1);
        step();
        drive(16'h0200, 1'b0, 1'b0, 3'd1, 1'b0);
        #1;
        chk("nolu_id_stall", 32'(id_stall), 32'd0);
        step();
        chk("nolu_ex_valid", 32'(ex_valid), 32'd1);
        chk("nolu_ex_is_load", 32'(ex_is_load), 32'd0);

        // Backpressure: hold for 3 cycles
        ex_ready = 1'b0;
        drive(16'h0600, 1'b1, 1'b0, 3'd3, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_id_stall", c), 32'(id_stall), 32'd1);
            step();
            chk($sformatf("bp%0d_ex_valid", c), 32'(ex_valid), 32'd1);
            chk($sformatf("bp%0d_ex_rs", c), 32'(ex_rs), 32'd2);
            chk($sformatf("bp%0d_ex_dst", c), 32'(ex_dst), 32'd1);
        end
        ex_ready = 1'b1;
        #1;
        chk("bp_release_stall", 32'(id_stall), 32'd0);
        step();
        chk("bp_release_rs", 32'(ex_rs), 32'd6);
        chk("bp_release_dst", 32'(ex_dst), 32'd3);

        // Flush during hazard plus backpressure, with ctrl_err on the killed instr
        drive(16'h0000, 1'b0, 1'b0, 3'd6, 1'b1);
        step();
        ex_ready = 1'b0;
        drive(16'h0600, 1'b1, 1'b0, 3'd1, 1'b0);
        #1;
        chk("fl_pre_stall", 32'(id_stall), 32'd1);
        ex_flush = 1'b1;
        ctrl_err = 1'b1;
        #1;
        chk("fl_id_stall", 32'(id_stall), 32'd0);
        step();
        chk("fl_ex_valid", 32'(ex_valid), 32'd0);
        chk("fl_err", 32'(err), 32'd0);
        ex_flush = 1'b0;
        ctrl_err = 1'b0;
        ex_ready = 1'b1;

        // Sticky err
        drive(16'h0100, 1'b0, 1'b0, 3'd0, 1'b0);
        ctrl_err = 1'b1;
        step();
        chk("err_set", 32'(err), 32'd1);
        ctrl_err = 1'b0;
        step();
        step();
        chk("err_held", 32'(err), 32'd1);
        chk("err_held_valid", 32'(ex_valid), 32'd1);

        // Mid-stream reset drops everything, including register contents
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(ex_valid), 32'd0);
        chk("rst_mid_err", 32'(err), 32'd0);
        step();
        rst = 1'b0;
        drive(16'h0300, 1'b1, 1'b0, 3'd0, 1'b0);
        step();
        chk("rst_rf_cleared", ex_a, 32'd0);
        chk("rst_err_stays0", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
